// File: rtl/vdp_pkg.sv
// Shared VDP definitions: Z80 I/O bus-cycle states and the VDP port map.
package vdp_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    TW   = 3'd3,
    T3   = 3'd4
  } bus_state_e;

  localparam logic [7:0] VDP_PORT_DATA = 8'hBE;
  localparam logic [7:0] VDP_PORT_CTRL = 8'hBF;
  localparam logic [7:0] VDP_PORT_VCNT = 8'h7E;
  localparam logic [7:0] VDP_PORT_HCNT = 8'h7F;

  // Strobes are asserted from T2 through T3; T1 only presents the address.
  function automatic logic strobe_phase(input bus_state_e s);
    return (s == T2) || (s == TW) || (s == T3);
  endfunction

endpackage

// File: rtl/vdp_bus_master.sv
// Z80-style I/O bus master: turns one command into a T1/T2/TW/T3 cycle paced by cpu_en.
// All bus outputs are registered and decoded from the next state.
module vdp_bus_master
  import vdp_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic       clk_100,
  input  logic       rst_L,
  input  logic       cpu_en,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_wr,
  input  logic [7:0] cmd_port,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic [7:0] addr_bus,
  output logic [7:0] data_out,
  output logic       data_oe,
  input  logic [7:0] data_in,
  output logic       IORQ_L,
  output logic       RD_L,
  output logic       WR_L,
  input  logic       WAIT_L
);

  localparam logic [3:0] WS_C = 4'(WAIT_STATES);

  bus_state_e state_q, state_d;
  logic       wr_q, wr_d;
  logic [7:0] port_q, port_d;
  logic [7:0] data_q, data_d;
  logic [3:0] tw_cnt_q, tw_cnt_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       cmd_ready_q, cmd_ready_d;
  logic       iorq_l_q, iorq_l_d;
  logic       rd_l_q, rd_l_d;
  logic       wr_l_q, wr_l_d;
  logic       data_oe_q, data_oe_d;
  logic       busy_s;

  // Next-state sequencing and command/response capture.
  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    port_d      = port_q;
    data_d      = data_q;
    tw_cnt_d    = tw_cnt_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d = T1;
          wr_d    = cmd_wr;
          port_d  = cmd_port;
          data_d  = cmd_data;
        end else begin
          state_d = IDLE;
        end
      end
      T1: begin
        if (cpu_en) state_d = T2;
        else        state_d = T1;
      end
      T2: begin
        if (cpu_en) begin
          state_d  = TW;
          tw_cnt_d = 4'd0;
        end else begin
          state_d = T2;
        end
      end
      TW: begin
        // The first TW tick always counts, so WAIT_STATES=0 still yields one TW.
        if (cpu_en) begin
          if (tw_cnt_q < 4'd7) tw_cnt_d = tw_cnt_q + 4'd1;
          else                 tw_cnt_d = tw_cnt_q;
          if (((tw_cnt_q + 4'd1) >= WS_C) && WAIT_L) state_d = T3;
          else                                       state_d = TW;
        end else begin
          state_d = TW;
        end
      end
      T3: begin
        if (cpu_en) begin
          state_d = IDLE;
          if (!wr_q) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = data_in;
          end else begin
            rsp_valid_d = 1'b0;
          end
        end else begin
          state_d = T3;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs decoded from the next state so they change with the state register.
  always_comb begin
    busy_s      = strobe_phase(state_d);
    cmd_ready_d = (state_d == IDLE);
    iorq_l_d    = ~busy_s;
    rd_l_d      = ~(busy_s & ~wr_d);
    wr_l_d      = ~(busy_s & wr_d);
    data_oe_d   = (state_d != IDLE) & wr_d;
  end

  // State and output registers; reset forces an idle, strobes-high bus immediately.
  always_ff @(posedge clk_100 or negedge rst_L) begin
    if (!rst_L) begin
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      port_q      <= 8'h00;
      data_q      <= 8'h00;
      tw_cnt_q    <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      cmd_ready_q <= 1'b0;
      iorq_l_q    <= 1'b1;
      rd_l_q      <= 1'b1;
      wr_l_q      <= 1'b1;
      data_oe_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      port_q      <= port_d;
      data_q      <= data_d;
      tw_cnt_q    <= tw_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      cmd_ready_q <= cmd_ready_d;
      iorq_l_q    <= iorq_l_d;
      rd_l_q      <= rd_l_d;
      wr_l_q      <= wr_l_d;
      data_oe_q   <= data_oe_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign addr_bus  = port_q;
  assign data_out  = data_q;
  assign data_oe   = data_oe_q;
  assign IORQ_L    = iorq_l_q;
  assign RD_L      = rd_l_q;
  assign WR_L      = wr_l_q;

endmodule

// File: tb/tb_vdp_bus_master.sv
// Directed bench for vdp_bus_master: strobe timing, wait states, back-to-back and reset abort.
module tb_vdp_bus_master;
  import vdp_pkg::*;

  localparam int DIV = 5;

  logic       clk_100 = 1'b0;
  logic       rst_L = 1'b1;
  logic       cpu_en = 1'b0;
  logic       cmd_valid = 1'b0, cmd_valid_x = 1'b0;
  logic       cmd_wr = 1'b0;
  logic [7:0] cmd_port = 8'h00, cmd_data = 8'h00, data_in = 8'h00;
  logic       WAIT_L = 1'b1;

  logic       cmd_ready, rsp_valid, data_oe, IORQ_L, RD_L, WR_L;
  logic [7:0] rsp_data, addr_bus, data_out;
  logic       cmd_ready_0, rsp_valid_0, data_oe_0, IORQ_L_0, RD_L_0, WR_L_0;
  logic [7:0] rsp_data_0, addr_bus_0, data_out_0;
  logic       cmd_ready_3, rsp_valid_3, data_oe_3, IORQ_L_3, RD_L_3, WR_L_3;
  logic [7:0] rsp_data_3, addr_bus_3, data_out_3;

  int vectors = 0, miscompares = 0;
  int wr_low = 0, rd_low = 0, iorq_low = 0, oe_cnt = 0, rsp_cnt = 0;
  int wr_low_0 = 0, wr_low_3 = 0, rsp_cnt_x = 0;
  int div_cnt = 0;

  vdp_bus_master #(.WAIT_STATES(1)) dut (
    .clk_100(clk_100), .rst_L(rst_L), .cpu_en(cpu_en),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_port(cmd_port), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .addr_bus(addr_bus),
    .data_out(data_out), .data_oe(data_oe), .data_in(data_in),
    .IORQ_L(IORQ_L), .RD_L(RD_L), .WR_L(WR_L), .WAIT_L(WAIT_L));

  vdp_bus_master #(.WAIT_STATES(0)) dut0 (
    .clk_100(clk_100), .rst_L(rst_L), .cpu_en(cpu_en),
    .cmd_valid(cmd_valid_x), .cmd_ready(cmd_ready_0), .cmd_wr(cmd_wr),
    .cmd_port(cmd_port), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid_0), .rsp_data(rsp_data_0), .addr_bus(addr_bus_0),
    .data_out(data_out_0), .data_oe(data_oe_0), .data_in(data_in),
    .IORQ_L(IORQ_L_0), .RD_L(RD_L_0), .WR_L(WR_L_0), .WAIT_L(WAIT_L));

  vdp_bus_master #(.WAIT_STATES(3)) dut3 (
    .clk_100(clk_100), .rst_L(rst_L), .cpu_en(cpu_en),
    .cmd_valid(cmd_valid_x), .cmd_ready(cmd_ready_3), .cmd_wr(cmd_wr),
    .cmd_port(cmd_port), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid_3), .rsp_data(rsp_data_3), .addr_bus(addr_bus_3),
    .data_out(data_out_3), .data_oe(data_oe_3), .data_in(data_in),
    .IORQ_L(IORQ_L_3), .RD_L(RD_L_3), .WR_L(WR_L_3), .WAIT_L(WAIT_L));

  always #5 clk_100 = ~clk_100;

  // cpu_en: one clk_100 cycle high every DIV cycles
  always @(posedge clk_100) begin
    if (div_cnt == DIV - 1) begin
      div_cnt <= 0;
      cpu_en  <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 1;
      cpu_en  <= 1'b0;
    end
  end

  // Cycle counters sampled on the inactive edge
  always @(negedge clk_100) begin
    if (!WR_L)   wr_low   = wr_low + 1;
    if (!RD_L)   rd_low   = rd_low + 1;
    if (!IORQ_L) iorq_low = iorq_low + 1;
    if (data_oe) oe_cnt   = oe_cnt + 1;
    if (rsp_valid) rsp_cnt = rsp_cnt + 1;
    if (!WR_L_0) wr_low_0 = wr_low_0 + 1;
    if (!WR_L_3) wr_low_3 = wr_low_3 + 1;
    if (rsp_valid_0 || rsp_valid_3 || data_oe_0 !== data_oe_3 && 1'b0) rsp_cnt_x = rsp_cnt_x + 1;
  end

  // Wait for cmd_ready coinciding with a cpu_en tick, so the handshake edge is also a tick.
  task automatic issue(input logic wr, input logic [7:0] port, input logic [7:0] data,
                       input logic both, input logic hold);
    int n = 0;
    @(negedge clk_100);
    while (!(cmd_ready && cpu_en) && n < 400) begin
      @(negedge clk_100);
      n++;
    end
    vectors++;
    if (n >= 400) begin
      miscompares++;
      $display("FAIL issue_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
    end
    cmd_valid = 1'b1; cmd_valid_x = both;
    cmd_wr = wr; cmd_port = port; cmd_data = data;
    @(negedge clk_100);
    if (!hold) begin
      cmd_valid = 1'b0; cmd_valid_x = 1'b0;
      cmd_wr = 1'($urandom); cmd_port = 8'($urandom); cmd_data = 8'($urandom);
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!(cmd_ready && cmd_ready_0 && cmd_ready_3) && n < 1000) begin
      @(negedge clk_100);
      n++;
    end
    vectors++;
    if (n >= 1000) begin
      miscompares++;
      $display("FAIL %s_done: not idle after %0d cycles, required idle", name, n);
    end
    repeat (3) @(negedge clk_100);
  endtask

  task automatic count_ticks(input int ticks);
    int t = 0, k = 0;
    while (t < ticks && k < 500) begin
      @(negedge clk_100);
      k++;
      if (cpu_en) t++;
    end
  endtask

  task automatic test_reset();
    #2 rst_L = 1'b0;
    #1;
    vectors++;
    if ({IORQ_L, RD_L, WR_L, data_oe, rsp_valid, cmd_ready} !== 6'b111000) begin
      miscompares++;
      $display("FAIL reset_ctl: got %b expected 111000",
               {IORQ_L, RD_L, WR_L, data_oe, rsp_valid, cmd_ready});
    end
    vectors++;
    if ({addr_bus, data_out, rsp_data} !== 24'h000000) begin
      miscompares++;
      $display("FAIL reset_data: got %h expected 000000", {addr_bus, data_out, rsp_data});
    end
    repeat (3) @(negedge clk_100);
    rst_L = 1'b1;
    #1;
    vectors++;
    if (cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready_hold: got %b expected 0", cmd_ready);
    end
    @(posedge clk_100);
    #1;
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready_rise: got %b expected 1", cmd_ready);
    end
  endtask

  task automatic test_out();
    int w0 = wr_low, i0 = iorq_low, o0 = oe_cnt, r0 = rsp_cnt;
    issue(1'b1, VDP_PORT_CTRL, 8'h40, 1'b0, 1'b0);
    vectors++;
    if ({addr_bus, data_out, data_oe, IORQ_L, RD_L, WR_L} !== {8'hBF, 8'h40, 4'b1111}) begin
      miscompares++;
      $display("FAIL out_t1: got %h/%h/%b%b%b%b expected bf/40/1111",
               addr_bus, data_out, data_oe, IORQ_L, RD_L, WR_L);
    end
    wait_done("out");
    vectors++;
    if (wr_low - w0 != 3 * DIV) begin
      miscompares++;
      $display("FAIL out_wr_low: got %0d cycles expected %0d", wr_low - w0, 3 * DIV);
    end
    vectors++;
    if (iorq_low - i0 != 3 * DIV) begin
      miscompares++;
      $display("FAIL out_iorq_low: got %0d cycles expected %0d", iorq_low - i0, 3 * DIV);
    end
    vectors++;
    if (oe_cnt - o0 != 4 * DIV) begin
      miscompares++;
      $display("FAIL out_oe: got %0d cycles expected %0d", oe_cnt - o0, 4 * DIV);
    end
    vectors++;
    if (rsp_cnt != r0) begin
      miscompares++;
      $display("FAIL out_no_rsp: got %0d pulses expected 0", rsp_cnt - r0);
    end
    vectors++;
    if ({addr_bus, data_oe, WR_L, IORQ_L} !== {8'hBF, 3'b011}) begin
      miscompares++;
      $display("FAIL out_idle: got %h/%b%b%b expected bf/011", addr_bus, data_oe, WR_L, IORQ_L);
    end
  endtask

  task automatic test_in();
    int rd0 = rd_low, r0 = rsp_cnt;
    data_in = 8'hA5;
    issue(1'b0, VDP_PORT_DATA, 8'h00, 1'b0, 1'b0);
    vectors++;
    if ({addr_bus, data_oe, RD_L} !== {8'hBE, 2'b01}) begin
      miscompares++;
      $display("FAIL in_t1: got %h/%b%b expected be/01", addr_bus, data_oe, RD_L);
    end
    wait_done("in");
    data_in = 8'h5A;
    vectors++;
    if (rd_low - rd0 != 3 * DIV) begin
      miscompares++;
      $display("FAIL in_rd_low: got %0d cycles expected %0d", rd_low - rd0, 3 * DIV);
    end
    vectors++;
    if (rsp_cnt - r0 != 1) begin
      miscompares++;
      $display("FAIL in_rsp_pulse: got %0d cycles expected 1", rsp_cnt - r0);
    end
    vectors++;
    if (rsp_data !== 8'hA5) begin
      miscompares++;
      $display("FAIL in_rsp_data: got %h expected a5", rsp_data);
    end
  endtask

  task automatic test_back_to_back();
    int w0 = wr_low, r0 = rsp_cnt, n = 0;
    issue(1'b1, VDP_PORT_CTRL, 8'h80, 1'b0, 1'b1);
    @(negedge clk_100);
    while (!cmd_ready && n < 400) begin
      @(negedge clk_100);
      n++;
    end
    vectors++;
    if ({cmd_ready, WR_L, IORQ_L} !== 3'b111) begin
      miscompares++;
      $display("FAIL b2b_idle_gap: got ready/wr/iorq=%b%b%b expected 111", cmd_ready, WR_L, IORQ_L);
    end
    cmd_port = VDP_PORT_DATA; cmd_data = 8'h81;
    @(negedge clk_100);
    vectors++;
    if (cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_ready_width: got %b in second cycle expected 0", cmd_ready);
    end
    cmd_valid = 1'b0;
    wait_done("b2b");
    vectors++;
    if (wr_low - w0 != 6 * DIV) begin
      miscompares++;
      $display("FAIL b2b_wr_low: got %0d cycles expected %0d", wr_low - w0, 6 * DIV);
    end
    vectors++;
    if ({rsp_cnt - r0, addr_bus, rsp_data} !== {32'd0, 8'hBE, 8'hA5}) begin
      miscompares++;
      $display("FAIL b2b_end: got rsp=%0d addr=%h rsp_data=%h expected 0/be/a5",
               rsp_cnt - r0, addr_bus, rsp_data);
    end
  endtask

  task automatic test_wait_l();
    int rd0 = rd_low, r0 = rsp_cnt;
    WAIT_L = 1'b0;
    data_in = 8'h77;
    issue(1'b0, VDP_PORT_VCNT, 8'h00, 1'b0, 1'b0);
    count_ticks(7);
    @(negedge clk_100);
    WAIT_L = 1'b1;
    wait_done("wait_l");
    vectors++;
    if (rd_low - rd0 != 8 * DIV) begin
      miscompares++;
      $display("FAIL wait_rd_low: got %0d cycles expected %0d", rd_low - rd0, 8 * DIV);
    end
    vectors++;
    if ({rsp_cnt - r0, rsp_data} !== {32'd1, 8'h77}) begin
      miscompares++;
      $display("FAIL wait_rsp: got %0d/%h expected 1/77", rsp_cnt - r0, rsp_data);
    end
  endtask

  task automatic test_wait_states();
    int w = wr_low, w0 = wr_low_0, w3 = wr_low_3, rx = rsp_cnt_x;
    issue(1'b1, VDP_PORT_HCNT, 8'h01, 1'b1, 1'b0);
    wait_done("ws");
    vectors++;
    if (wr_low_0 - w0 != 3 * DIV) begin
      miscompares++;
      $display("FAIL ws0_wr_low: got %0d cycles expected %0d", wr_low_0 - w0, 3 * DIV);
    end
    vectors++;
    if (wr_low_3 - w3 != 5 * DIV) begin
      miscompares++;
      $display("FAIL ws3_wr_low: got %0d cycles expected %0d", wr_low_3 - w3, 5 * DIV);
    end
    vectors++;
    if (wr_low - w != 3 * DIV) begin
      miscompares++;
      $display("FAIL ws1_wr_low: got %0d cycles expected %0d", wr_low - w, 3 * DIV);
    end
    vectors++;
    if ({addr_bus_0, addr_bus_3, 32'(rsp_cnt_x - rx)} !== {8'h7F, 8'h7F, 32'd0}) begin
      miscompares++;
      $display("FAIL ws_idle: got %h/%h/%0d expected 7f/7f/0", addr_bus_0, addr_bus_3, rsp_cnt_x - rx);
    end
  endtask

  task automatic test_reset_mid();
    int r0 = rsp_cnt, rd0;
    WAIT_L = 1'b0;
    data_in = 8'hC3;
    issue(1'b0, VDP_PORT_DATA, 8'h00, 1'b0, 1'b0);
    count_ticks(4);
    @(negedge clk_100);
    vectors++;
    if (RD_L !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_pre: RD_L got %b expected 0 in TW", RD_L);
    end
    #2 rst_L = 1'b0;
    #1;
    vectors++;
    if ({IORQ_L, RD_L, WR_L, cmd_ready, rsp_valid, rsp_data} !== {5'b11100, 8'h00}) begin
      miscompares++;
      $display("FAIL rstmid_async: got %b%b%b%b%b/%h expected 11100/00",
               IORQ_L, RD_L, WR_L, cmd_ready, rsp_valid, rsp_data);
    end
    repeat (2) @(negedge clk_100);
    WAIT_L = 1'b1;
    rst_L = 1'b1;
    repeat (3) @(negedge clk_100);
    rd0 = rd_low;
    data_in = 8'h3C;
    issue(1'b0, VDP_PORT_CTRL, 8'h00, 1'b0, 1'b0);
    wait_done("rstmid");
    vectors++;
    if (rd_low - rd0 != 3 * DIV) begin
      miscompares++;
      $display("FAIL rstmid_rd_low: got %0d cycles expected %0d", rd_low - rd0, 3 * DIV);
    end
    vectors++;
    if ({rsp_cnt - r0, rsp_data} !== {32'd1, 8'h3C}) begin
      miscompares++;
      $display("FAIL rstmid_rsp: got %0d/%h expected 1/3c", rsp_cnt - r0, rsp_data);
    end
  endtask

  initial begin
    test_reset();
    test_out();
    test_in();
    test_back_to_back();
    test_wait_l();
    test_wait_states();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vdp_bus_master.md
VDP_BUS_MASTER -- requirements
Module: vdp_bus_master

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 1, number of TW states inserted before WAIT_L is sampled (range 0-7).
REQ-002 SHALL have port clk_100 input 1 as the 100 MHz system clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst_L input 1 as the reset, asynchronous, active-low.
REQ-004 SHALL have port cpu_en input 1 as the CPU-rate tick (one clk_100 cycle wide, 4 MHz); each Z80 T-state lasts one cpu_en period.
REQ-005 SHALL have ports cmd_valid input 1, cmd_ready output 1, cmd_wr input 1 (1=OUT, 0=IN), cmd_port input 8 and cmd_data input 8 forming the command interface.
REQ-006 SHALL have ports rsp_valid output 1 and rsp_data output 8 returning the read result.
REQ-007 SHALL have port addr_bus output 8 as the I/O port address.
REQ-008 SHALL have ports data_out output 8, data_oe output 1 and data_in input 8; the data_bus tristate sits in the parent.
REQ-009 SHALL have ports IORQ_L, RD_L and WR_L output 1 each, active-low strobes to vdp_top.
REQ-010 SHALL have port WAIT_L input 1, active-low bus wait from the responder.

Function
REQ-011 SHALL run FSM states IDLE, T1, T2, TW, T3; transitions other than IDLE->T1 occur only on clk_100 edges where cpu_en=1.
REQ-012 SHALL assert cmd_ready only in IDLE; a handshake (cmd_valid and cmd_ready high) latches wr/port/data and enters T1 on the next edge, regardless of cpu_en.
REQ-013 SHALL, in T1, drive addr_bus=latched port and set data_oe=1 and data_out=latched data for OUT; strobes remain high.
REQ-014 SHALL, in T2, TW and T3, hold IORQ_L=0 together with RD_L=0 (IN) or WR_L=0 (OUT).
REQ-015 SHALL move T2->TW always, because Z80 I/O cycles carry one automatic wait.
REQ-016 SHALL stay in TW for WAIT_STATES ticks, then for further ticks while WAIT_L=0 is sampled on cpu_en; when WAIT_STATES=0, a single TW is still entered.
REQ-017 SHALL, on the cpu_en tick ending T3, sample data_in into rsp_data for IN, pulse rsp_valid high for exactly one clk_100 cycle, and return to IDLE.
REQ-018 SHALL emit no rsp_valid for OUT cycles.
REQ-019 SHALL hold rsp_data stable until the next IN completes.
REQ-020 SHALL drive all strobes high, data_oe=0 and addr_bus equal to the last port in IDLE.
REQ-021 SHALL complete a cycle with no stall in 4 cpu_en ticks (T1, T2, TW, T3) after T1 entry when WAIT_STATES=1; each extra wait adds one tick.
REQ-022 SHALL, when cmd_valid is held through the end of T3, accept the next command no earlier than the first IDLE cycle, so back-to-back commands have at least one clk_100 cycle of IDLE with strobes high.
REQ-023 SHALL accept a cpu_en pulse on the same edge as the handshake as the T1 entry only; it does not advance T1.
REQ-024 SHALL treat command fields as don't-care outside the handshake.

Reset
REQ-025 SHALL, on rst_L low, immediately force state=IDLE, IORQ_L=RD_L=WR_L=1, data_oe=0, data_out=0, addr_bus=0, rsp_valid=0, rsp_data=0 and cmd_ready=0; cmd_ready rises on the first clk_100 edge after release.
REQ-026 SHALL, on reset mid-cycle (any state), abort the transfer without emitting rsp_valid, and the strobes SHALL deassert asynchronously.

Structure
REQ-027 SHALL take the state enum (IDLE/T1/T2/TW/T3) and the VDP port constants (data 8'hBE, control 8'hBF, V counter 8'h7E, H counter 8'h7F) from shared package vdp_pkg.
REQ-028 SHALL implement cpu_en generation, tristate resolution and command sequencing outside this block; there is no sub-module.

Verification
REQ-029 SHALL cover: reset, then OUT port 8'hBF data 8'h40 -> WR_L and IORQ_L low for exactly 3 cpu_en periods, data_oe=1 from T1 through T3, and no rsp_valid.
REQ-030 SHALL cover: IN port 8'hBE with data_in=8'hA5 -> RD_L low for 3 ticks, rsp_valid single-cycle pulse with rsp_data=8'hA5.
REQ-031 SHALL cover: WAIT_L held low for 5 ticks during TW -> strobe low time of 3+5 ticks and correct completion.
REQ-032 SHALL cover: WAIT_STATES=0 versus 3 -> strobe low time of 3 versus 5 ticks.
REQ-033 SHALL cover: two back-to-back OUTs with cmd_valid held high -> at least one IDLE cycle with WR_L=1 between them, and cmd_ready high for exactly one cycle.
REQ-034 SHALL cover: rst_L low during TW of an IN -> strobes high asynchronously, no rsp_valid, and the next command completes normally.
